// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Optional early termination is selected by the MULT_EARLY_TERM_EN macro.
package mult_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int CNT_W_DEF  = 6;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_FIN  = 2'b10
    } mult_state_e;

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: used for operand magnitudes and
// for restoring the sign of the final product.
module mult_abs #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Negate when requested, otherwise pass through
    always_comb begin
        if (neg) begin
            dout = ~din + W'(1);
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU; mult_done low while busy.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_e,
    input  logic             signed_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    output logic             mult_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;

    mult_state_e      state_r;
    mult_state_e      state_nxt_s;
    logic             start_q_r;
    logic [WIDTH-1:0] mag_a_r;
    logic [WIDTH-1:0] mag_b_r;
    logic             neg_r;
    logic [PW-1:0]    acc_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [PW-1:0]    prod_s;
    logic             accept_s;
    logic             last_s;

    mult_abs #(.W(WIDTH)) u_abs_a (
        .neg  (signed_e & srca_e[WIDTH-1]),
        .din  (srca_e),
        .dout (mag_a_s)
    );

    mult_abs #(.W(WIDTH)) u_abs_b (
        .neg  (signed_e & srcb_e[WIDTH-1]),
        .din  (srcb_e),
        .dout (mag_b_s)
    );

    mult_abs #(.W(PW)) u_fix (
        .neg  (neg_r),
        .din  (acc_r),
        .dout (prod_s)
    );

    // A held start_e must launch only once, so accept on its rising edge only
    assign accept_s = (state_r == ST_IDLE) & start_e & ~start_q_r;

`ifdef MULT_EARLY_TERM_EN
    assign last_s = (count_r == CNT_W'(WIDTH - 1)) |
                    (mag_b_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    assign last_s = (count_r == CNT_W'(WIDTH - 1));
`endif

    assign mult_done = (state_r == ST_IDLE);
    assign hi        = hi_r;
    assign lo        = lo_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Start edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= start_e;
        end
    end

    // Operand latch, shift-add accumulation and result write-back
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_a_r <= {WIDTH{1'b0}};
            mag_b_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            acc_r   <= {PW{1'b0}};
            count_r <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mag_a_r <= mag_a_s;
                        mag_b_r <= mag_b_s;
                        neg_r   <= signed_e & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
                        acc_r   <= {PW{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                ST_BUSY: begin
                    // Product of two magnitudes fits in PW bits, so no carry out
                    if (mag_b_r[0]) begin
                        acc_r <= acc_r + ({{WIDTH{1'b0}}, mag_a_r} << count_r);
                    end
                    mag_b_r <= mag_b_r >> 1;
                    count_r <= count_r + CNT_W'(1);
                end
                ST_FIN: begin
                    hi_r <= prod_s[PW-1:WIDTH];
                    lo_r <= prod_s[WIDTH-1:0];
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: random and directed MULT/MULTU operations
// compared against plain 64-bit arithmetic, including busy latency.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_e;
    logic        signed_e;
    logic [31:0] srca_e;
    logic [31:0] srcb_e;
    logic        mult_done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } dchk_t;

    exp_t  sb_q[$];
    dchk_t d_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_e   (start_e),
        .signed_e  (signed_e),
        .srca_e    (srca_e),
        .srcb_e    (srcb_e),
        .mult_done (mult_done),
        .hi        (hi),
        .lo        (lo)
    );

    function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic s);
        longint pa;
        longint pb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            return 64'(pa * pb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    function automatic int ref_lat(logic [31:0] b, logic s);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        m = (s && b[31]) ? (32'd0 - b) : b;
        if (m == 32'd0) return 2;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return i + 2;
        end
        return 2;
`else
        if (s) return 33;
        return 33 + 0 * int'(b[0]);
`endif
    endfunction

    task automatic post(string n, logic [63:0] act, logic [63:0] exp);
        dchk_t d;
        d.name = n;
        d.act  = act;
        d.exp  = exp;
        d_q.push_back(d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((!mult_done || sb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) post("timeout", 64'd0, 64'd1);
    endtask

    task automatic launch(logic [31:0] a, logic [31:0] b, logic s);
        exp_t e;
        @(negedge clk);
        srca_e   = a;
        srcb_e   = b;
        signed_e = s;
        start_e  = 1'b1;
        e.prod   = ref_prod(a, b, s);
        e.lat    = ref_lat(b, s);
        sb_q.push_back(e);
    endtask

    task automatic do_op(logic [31:0] a, logic [31:0] b, logic s);
        wait_idle();
        launch(a, b, s);
        @(negedge clk);
        start_e  = 1'b0;
        srca_e   = $urandom;
        srcb_e   = $urandom;
        signed_e = 1'($urandom_range(0, 1));
        wait_idle();
    endtask

    // Monitor: direct checks, result/latency scoreboard and hold-during-busy
    int          low_cnt   = 0;
    logic        prev_done = 1'b1;
    logic [63:0] prev_prod = 64'd0;
    always @(negedge clk) begin
        dchk_t d;
        exp_t  e;
        while (d_q.size() > 0) begin
            d = d_q.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", d.name, d.act, d.exp);
            end
        end
        if (!reset_n) begin
            low_cnt   = 0;
            prev_done = 1'b1;
            prev_prod = 64'd0;
        end else begin
            if (!mult_done) begin
                low_cnt++;
                checks++;
                if ({hi, lo} !== prev_prod) begin
                    errors++;
                    $display("FAIL hold actual=%h required=%h", {hi, lo}, prev_prod);
                end
            end else if (!prev_done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_op actual=%h required=none", {hi, lo});
                end else begin
                    e = sb_q.pop_front();
                    if ({hi, lo} !== e.prod) begin
                        errors++;
                        $display("FAIL product actual=%h required=%h", {hi, lo}, e.prod);
                    end
                    checks++;
                    if (low_cnt != e.lat) begin
                        errors++;
                        $display("FAIL latency actual=%0d required=%0d", low_cnt, e.lat);
                    end
                    prev_prod = e.prod;
                end
                low_cnt = 0;
            end
            prev_done = mult_done;
        end
    end

    initial begin
        reset_n  = 1'b0;
        start_e  = 1'b0;
        signed_e = 1'b0;
        srca_e   = 32'd0;
        srcb_e   = 32'd0;
        #2;
        post("rst_done", 64'(mult_done), 64'd1);
        post("rst_hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        do_op(32'd12345, 32'd1, 1'b0);
        do_op(32'd9, 32'd0, 1'b1);

        // Held start_e: exactly one launch
        wait_idle();
        launch(32'd1000, 32'hFFFF_FFF0, 1'b1);
        repeat (40) @(negedge clk);
        post("held_done", 64'(mult_done), 64'd1);
        post("held_queue", 64'(sb_q.size()), 64'd0);
        start_e = 1'b0;
        @(negedge clk);

        // Operand changes and start pulses while busy are ignored
        wait_idle();
        launch(32'd6, 32'd5, 1'b0);
        @(negedge clk);
        start_e = 1'b0;
        @(negedge clk);
        srca_e  = 32'd77;
        srcb_e  = 32'd99;
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        wait_idle();

        // Asynchronous reset mid-operation
        @(negedge clk);
        srca_e  = 32'h1234_5678;
        srcb_e  = 32'hFFFF_FFFF;
        signed_e = 1'b0;
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        repeat (5) @(negedge clk);
        post("busy_before_rst", 64'(mult_done), 64'd0);
        reset_n = 1'b0;
        #1;
        post("abort_done", 64'(mult_done), 64'd1);
        post("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case (i % 4)
                1: b = b >> $urandom_range(0, 31);
                2: a = {a[31], 31'd0};
                3: b = 32'(i);
                default: a = a;
            endcase
            do_op(a, b, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative radix-2 shift-add multiplier for the MIPS MULT/MULTU instructions. It is the producer of the `mult_done` stall-request signal consumed by the pipeline hazard logic.
- Launched from the execute stage. Computes a 2×WIDTH product into HI/LO registers over multiple cycles.
- Holds `mult_done` low while busy so the front end stalls.

Parameters:
- WIDTH, 32, operand width; the product is 2×WIDTH, split into hi/lo of WIDTH each.
- CNT_W, 6, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start_e  in  1  multiply request from the execute stage, level; edge-qualified internally.
- signed_e  in  1  1 = MULT (two's complement), 0 = MULTU.
- srca_e  in  WIDTH  multiplicand (rs value after forwarding).
- srcb_e  in  WIDTH  multiplier (rt value after forwarding).
- mult_done  out  1  1 = idle/result valid, 0 = busy; feeds the hazard stall.
- hi  out  WIDTH  upper half of the last completed product.
- lo  out  WIDTH  lower half of the last completed product.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; hi=0, lo=0; mult_done=1.
  - Internal accumulator, operands, counter and start_q all 0.
- Start qualification:
  - start_q registers start_e every cycle.
  - A request is accepted only when state=IDLE, start_e=1 and start_q=0, i.e. a rising edge.
  - A start_e held high across a stall therefore launches exactly one operation.
- States:
  - IDLE: mult_done=1. On an accepted start, latch mag_a=|srca_e| and mag_b=|srcb_e| (absolute value only if signed_e=1, else raw). Latch neg = signed_e & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]). Clear acc, count=0, go to BUSY.
  - BUSY: mult_done=0. Each cycle:
    - if mag_b[0], acc += mag_a << count (2×WIDTH add, no overflow possible);
    - mag_b >>= 1; count++.
    - When count==WIDTH-1 is processed, go to FIN.
  - FIN: mult_done=0. Set {hi,lo} = neg ? -acc : acc (2×WIDTH two's complement). Go to IDLE.
- mult_done is decoded combinationally from state: 1 only in IDLE.
- Latency: accepted at edge N; mult_done low in cycles N+1 … N+WIDTH+1 (WIDTH+1 cycles); hi/lo valid and mult_done high from edge N+WIDTH+1.
- hi/lo change only on the FIN→IDLE transition; they hold the previous result during BUSY.
- start_e and operand changes during BUSY/FIN are ignored.
- signed_e=1 with the most-negative operand (0x80000000): the magnitude is 2^(WIDTH-1), which is exact as an unsigned WIDTH value; the result must be correct.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result is discarded.

Optional Feature:
- MULT_EARLY_TERM_EN
  - Defined: in BUSY, when the remaining mag_b==0, go to FIN immediately. Latency becomes (index of highest set bit of |b|)+2 cycles; b==0 takes 1 BUSY cycle then FIN.
  - Undefined: fixed WIDTH+1 cycle busy latency regardless of operands.
  - Results are identical in both cases.

Decomposition:
- Shared package mult_pkg:
  - state encoding (IDLE=2'b00, BUSY=2'b01, FIN=2'b10);
  - WIDTH/CNT_W defaults;
  - product-width constant 2×WIDTH.
- One natural sub-module, mult_abs: combinational conditional two's-complement negate, WIDTH and 2×WIDTH instances. Used for operand magnitude and result sign fix-up.
- The FSM and accumulator stay in mult_unit.

Test Plan:
- Reset → mult_done=1, hi=0, lo=0. Assert reset_n=0 mid-BUSY → mult_done=1 asynchronously, hi/lo=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. mult_done low exactly 33 cycles (fixed latency build).
- MULT −3 × 7 (0xFFFFFFFD, 0x00000007) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- start_e held high for 40 cycles → exactly one operation. hi/lo are updated once; mult_done stays 1 after completion; no relaunch until start_e drops and rises.
- During BUSY, change srca_e/srcb_e and pulse start_e → result reflects the originally latched operands (6×5 → lo=30, hi=0).
- MULT_EARLY_TERM_EN build: MULTU 12345 × 1 → mult_done low 2 cycles, lo=12345. Same product bit-exact versus the fixed-latency build over 1000 random signed/unsigned pairs.
